fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets one of NUM_REQ requesters
// stream a packet (bounded to MAX_BURST beats) into a single FIFO write port.
// Arbitration happens in IDLE; the owner streams in GRANT and releases on
// last, burst limit or dropping valid. An idle cycle always separates grants.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                            wr_clk,
  input  logic                            wr_rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_wr_data,
  input  logic                            fifo_full,
  input  logic                            fifo_overflow,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic [7:0]                      ovf_cnt
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [4:0]      beat_cnt_q, beat_cnt_d;
  logic [4:0]      cnt_inc;
  logic [7:0]      ovf_cnt_q;

  logic [IDW-1:0]  pick;
  logic            pick_vld;
  logic            g_valid;
  logic            g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic            rel;

  // Pointer after the owner, wrapping for non-power-of-two requester counts.
  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + 1'b1;
  endfunction

  // Increment that sticks at the top of the 8-bit range.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign cnt_inc  = beat_cnt_q + 5'd1;
  assign grant_id = gnt_q;
  assign busy     = (state_q == GRANT);
  assign ovf_cnt  = ovf_cnt_q;

  // Round-robin pick: first valid at or above rr_ptr, then wrap to the bottom.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!pick_vld && req_valid[j] && (j >= int'(rr_ptr_q))) begin
        pick     = IDW'(j);
        pick_vld = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!pick_vld && req_valid[j]) begin
        pick     = IDW'(j);
        pick_vld = 1'b1;
      end
    end
  end

  // Select the current owner's valid, last and data lanes.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt_q == IDW'(j)) begin
        g_valid = req_valid[j];
        g_last  = req_last[j];
        g_data  = req_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and handshake outputs; a full FIFO freezes everything in GRANT.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    rel          = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = GRANT;
          gnt_d      = pick;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        for (int j = 0; j < NUM_REQ; j++) begin
          req_ready[j] = (gnt_q == IDW'(j)) && !fifo_full;
        end
        fifo_wr_en   = g_valid && !fifo_full;
        fifo_wr_data = g_data;
        if (!fifo_full) begin
          if (g_valid) begin
            beat_cnt_d = cnt_inc;
            if (g_last || (cnt_inc == BURST_LIM)) rel = 1'b1;
          end else begin
            rel = 1'b1;
          end
        end
        if (rel) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr(gnt_q);
          gnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers with synchronous active-low reset.
  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Saturating count of cycles with the FIFO overflow flag raised.
  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      ovf_cnt_q <= '0;
    end else if (fifo_overflow) begin
      ovf_cnt_q <= sat_inc8(ovf_cnt_q);
    end
  end

endmodule
